fetch_stall_ctrl: RTL and testbench

FETCH_STALL_CTRL -- requirements
Module: fetch_stall_ctrl

---
 rtl/fetch_stall_ctrl_pkg.sv | 19 +
 rtl/fetch_stall_ctrl_sat_counter16.sv | 18 +
 rtl/fetch_stall_ctrl.sv | 134 +++++++++++++
 tb/tb_fetch_stall_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_stall_ctrl_pkg.sv
// Shared CPU constants for the fetch stage: FSM encoding, NOP word,
// PC step and the stall run-length timeout threshold.
package fetch_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_BOOT    = 2'd0,
        ST_RUN     = 2'd1,
        ST_STALLED = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;
    localparam logic [31:0] PC_INCR        = 32'd4;
    localparam logic [3:0]  TIMEOUT_THRESH = 4'd15;

    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + PC_INCR;
    endfunction

endpackage

// File: rtl/fetch_stall_ctrl_sat_counter16.sv
// 16-bit event counter that sticks at 0xFFFF instead of wrapping.
// Synchronous active-low reset.
module sat_counter16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    output logic [15:0] count
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= 16'h0000;
        end else if (inc && (count != 16'hFFFF)) begin
            count <= count + 16'h0001;
        end
    end

endmodule

// File: rtl/fetch_stall_ctrl.sv
// Fetch-stage PC and IF/ID register control with stall/flush handling,
// stall/flush statistics and a sticky long-stall timeout flag.
module fetch_stall_ctrl (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_pc_i,
    input  logic        stall_ifid_i,
    input  logic        flush_i,
    input  logic [31:0] target_i,
    input  logic [31:0] instr_i,
    output logic [31:0] pc_o,
    output logic [31:0] ifid_pc4_o,
    output logic [31:0] ifid_instr_o,
    output logic        ifid_valid_o,
    output logic [15:0] stall_cnt_o,
    output logic [15:0] flush_cnt_o,
    output logic        timeout_o
);

    import fetch_stall_ctrl_pkg::*;

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  ifid_pc4_q, ifid_pc4_d;
    logic [31:0]  ifid_instr_q, ifid_instr_d;
    logic         ifid_valid_q, ifid_valid_d;
    logic [3:0]   run_len_q, run_len_d;
    logic         timeout_q, timeout_d;
    logic         stall_inc;
    logic         flush_inc;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers share the FSM's reset so a reset mid-stall or
    // mid-flush leaves nothing behind.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            pc_q         <= 32'h0;
            ifid_pc4_q   <= 32'h0;
            ifid_instr_q <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
            run_len_q    <= 4'h0;
            timeout_q    <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
            run_len_q    <= run_len_d;
            timeout_q    <= timeout_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;
        run_len_d    = run_len_q;
        timeout_d    = timeout_q;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;

        case (state_q)
            ST_BOOT: begin
                state_d      = ST_RUN;
                ifid_pc4_d   = 32'h0;
                ifid_instr_d = NOP_INSTR;
                ifid_valid_d = 1'b0;
                run_len_d    = 4'h0;
            end
            default: begin
                if (flush_i) begin
                    state_d      = ST_RUN;
                    pc_d         = target_i;
                    ifid_pc4_d   = 32'h0;
                    ifid_instr_d = NOP_INSTR;
                    ifid_valid_d = 1'b0;
                    run_len_d    = 4'h0;
                    flush_inc    = 1'b1;
                end else begin
                    if (!stall_pc_i) begin
                        pc_d = next_pc(pc_q);
                    end
                    if (!stall_ifid_i) begin
                        state_d      = ST_RUN;
                        ifid_pc4_d   = next_pc(pc_q);
                        ifid_instr_d = instr_i;
                        ifid_valid_d = 1'b1;
                        run_len_d    = 4'h0;
                    end else begin
                        // Run length counts stalled cycles; the cycle that
                        // finds it already at threshold is the 16th in a row.
                        state_d   = ST_STALLED;
                        stall_inc = 1'b1;
                        if (run_len_q == TIMEOUT_THRESH) begin
                            timeout_d = 1'b1;
                        end else begin
                            run_len_d = run_len_q + 4'h1;
                        end
                    end
                end
            end
        endcase
    end

    sat_counter16 u_stall_cnt (
        .clk   (clk_i),
        .rst_n (rst_i),
        .inc   (stall_inc),
        .count (stall_cnt_o)
    );

    sat_counter16 u_flush_cnt (
        .clk   (clk_i),
        .rst_n (rst_i),
        .inc   (flush_inc),
        .count (flush_cnt_o)
    );

    assign pc_o         = pc_q;
    assign ifid_pc4_o   = ifid_pc4_q;
    assign ifid_instr_o = ifid_instr_q;
    assign ifid_valid_o = ifid_valid_q;
    assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_fetch_stall_ctrl.sv
// Directed self-checking bench for fetch_stall_ctrl: boot, stalls, flush,
// timeout, PC wrap, reset mid-stall and stall counter saturation.
module tb_fetch_stall_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        stall_pc_i;
    logic        stall_ifid_i;
    logic        flush_i;
    logic [31:0] target_i;
    logic [31:0] instr_i;
    logic [31:0] pc_o;
    logic [31:0] ifid_pc4_o;
    logic [31:0] ifid_instr_o;
    logic        ifid_valid_o;
    logic [15:0] stall_cnt_o;
    logic [15:0] flush_cnt_o;
    logic        timeout_o;

    int checks   = 0;
    int failures = 0;

    localparam logic [31:0] INSTR_A = 32'h8C01_0004;
    localparam logic [31:0] INSTR_B = 32'h1111_1111;

    fetch_stall_ctrl dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .stall_pc_i   (stall_pc_i),
        .stall_ifid_i (stall_ifid_i),
        .flush_i      (flush_i),
        .target_i     (target_i),
        .instr_i      (instr_i),
        .pc_o         (pc_o),
        .ifid_pc4_o   (ifid_pc4_o),
        .ifid_instr_o (ifid_instr_o),
        .ifid_valid_o (ifid_valid_o),
        .stall_cnt_o  (stall_cnt_o),
        .flush_cnt_o  (flush_cnt_o),
        .timeout_o    (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one cycle's inputs just after an edge, then advance past the next edge.
    task automatic apply_stimulus(input logic spc, input logic sifid, input logic fl,
                                  input logic [31:0] tgt, input logic [31:0] ins);
        stall_pc_i   = spc;
        stall_ifid_i = sifid;
        flush_i      = fl;
        target_i     = tgt;
        instr_i      = ins;
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_pc"}, pc_o, 32'h0);
        check_output({tag, "_pc4"}, ifid_pc4_o, 32'h0);
        check_output({tag, "_instr"}, ifid_instr_o, 32'h0);
        check_output({tag, "_valid"}, {31'b0, ifid_valid_o}, 32'h0);
        check_output({tag, "_scnt"}, {16'b0, stall_cnt_o}, 32'h0);
        check_output({tag, "_fcnt"}, {16'b0, flush_cnt_o}, 32'h0);
        check_output({tag, "_tmo"}, {31'b0, timeout_o}, 32'h0);
    endtask

    initial begin
        rst_i = 1'b0;
        apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, INSTR_A);
        check_all_zero("reset");

        // Boot sequence: PC 0,0,4,8 with valid IF/ID from the second cycle
        rst_i = 1'b1;
        apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, INSTR_A);
        check_output("boot_pc", pc_o, 32'h0);
        check_output("boot_valid", {31'b0, ifid_valid_o}, 32'h0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, INSTR_A);
        check_output("run1_pc", pc_o, 32'h4);
        check_output("run1_valid", {31'b0, ifid_valid_o}, 32'h1);
        check_output("run1_pc4", ifid_pc4_o, 32'h4);
        check_output("run1_instr", ifid_instr_o, INSTR_A);
        apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, INSTR_A);
        check_output("run2_pc", pc_o, 32'h8);
        apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, INSTR_A);
        apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, INSTR_A);
        check_output("run4_pc", pc_o, 32'h10);
        check_output("run4_pc4", ifid_pc4_o, 32'h10);

        // Both stalls for two cycles at 0x10
        apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0, INSTR_B);
        apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0, INSTR_B);
        check_output("stall_pc", pc_o, 32'h10);
        check_output("stall_pc4", ifid_pc4_o, 32'h10);
        check_output("stall_instr", ifid_instr_o, INSTR_A);
        check_output("stall_cnt2", {16'b0, stall_cnt_o}, 32'd2);
        apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, INSTR_B);
        check_output("unstall_pc", pc_o, 32'h14);
        check_output("unstall_pc4", ifid_pc4_o, 32'h14);
        check_output("unstall_instr", ifid_instr_o, INSTR_B);

        // Flush overrides both stalls
        apply_stimulus(1'b1, 1'b1, 1'b1, 32'h40, INSTR_B);
        check_output("flush_pc", pc_o, 32'h40);
        check_output("flush_valid", {31'b0, ifid_valid_o}, 32'h0);
        check_output("flush_instr", ifid_instr_o, 32'h0);
        check_output("flush_pc4", ifid_pc4_o, 32'h0);
        check_output("flush_fcnt", {16'b0, flush_cnt_o}, 32'd1);
        check_output("flush_scnt", {16'b0, stall_cnt_o}, 32'd2);
        apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, INSTR_A);
        check_output("postflush_pc", pc_o, 32'h44);
        check_output("postflush_pc4", ifid_pc4_o, 32'h44);

        // Independent stalls
        apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0, INSTR_A);
        check_output("spc_only_pc", pc_o, 32'h44);
        check_output("spc_only_pc4", ifid_pc4_o, 32'h48);
        apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0, INSTR_B);
        check_output("sifid_only_pc", pc_o, 32'h48);
        check_output("sifid_only_pc4", ifid_pc4_o, 32'h48);
        check_output("sifid_only_instr", ifid_instr_o, INSTR_A);
        apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, INSTR_A);
        check_output("indep_end_pc", pc_o, 32'h4C);

        // 15-cycle stall must not time out; 16 cycles must
        for (int i = 0; i < 15; i++) apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0, INSTR_A);
        check_output("tmo_15", {31'b0, timeout_o}, 32'h0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, INSTR_A);
        for (int i = 0; i < 15; i++) apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0, INSTR_A);
        check_output("tmo_15b", {31'b0, timeout_o}, 32'h0);
        apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0, INSTR_A);
        check_output("tmo_16", {31'b0, timeout_o}, 32'h1);
        apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, INSTR_A);
        check_output("tmo_sticky", {31'b0, timeout_o}, 32'h1);
        check_output("tmo_scnt", {16'b0, stall_cnt_o}, 32'd34);

        // PC wrap
        apply_stimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, INSTR_A);
        check_output("wrap_pre_pc", pc_o, 32'hFFFF_FFFC);
        check_output("wrap_fcnt", {16'b0, flush_cnt_o}, 32'd2);
        apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, INSTR_A);
        check_output("wrap_pc", pc_o, 32'h0);
        check_output("wrap_pc4", ifid_pc4_o, 32'h0);
        check_output("wrap_valid", {31'b0, ifid_valid_o}, 32'h1);

        // Reset in the middle of a stall and flush
        for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0, INSTR_B);
        rst_i = 1'b0;
        apply_stimulus(1'b1, 1'b1, 1'b1, 32'h80, INSTR_B);
        check_all_zero("midrst");
        rst_i = 1'b1;
        apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, INSTR_A);
        check_output("rstboot_pc", pc_o, 32'h0);
        check_output("rstboot_valid", {31'b0, ifid_valid_o}, 32'h0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, INSTR_A);
        check_output("rstrun_pc", pc_o, 32'h4);
        check_output("rstrun_valid", {31'b0, ifid_valid_o}, 32'h1);

        // Stall counter saturation
        for (int i = 0; i < 65534; i++) apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0, INSTR_A);
        check_output("sat_fffe", {16'b0, stall_cnt_o}, 32'h0000_FFFE);
        apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0, INSTR_A);
        check_output("sat_ffff", {16'b0, stall_cnt_o}, 32'h0000_FFFF);
        apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0, INSTR_A);
        check_output("sat_hold", {16'b0, stall_cnt_o}, 32'h0000_FFFF);
        check_output("sat_tmo", {31'b0, timeout_o}, 32'h1);
        check_output("sat_pc", pc_o, 32'h4 + 32'd4 * 32'd65536);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
